weight_load_seq: RTL and testbench



---
 rtl/weight_load_seq.sv | 90 +++++++++
 tb/tb_weight_load_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_seq.sv
// Weight column loader: accepts rows_to_load words from a valid/ready stream
// and writes them into row registers 0..len-1, one registered enable pulse per word.
module weight_load_seq #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  localparam int CW    = $clog2(ROWS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test_mode,
  input  logic              start,
  input  logic [CW-1:0]     rows_to_load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ROWS-1:0]   row_en,
  output logic [DATA_W-1:0] row_d,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | accepting words, cnt = next row to write
  // LAST  | final row write in flight, done issued on exit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   len, len_nxt;
  logic [CW-1:0]   len_clamped;
  logic            xfer;

  // Zero or out-of-range lengths load the whole column.
  assign len_clamped = (rows_to_load == '0 || rows_to_load > CW'(ROWS)) ? CW'(ROWS) : rows_to_load;

  assign in_ready = (state == LOAD) && !test_mode;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    case (state)
      IDLE: begin
        if (start && !test_mode) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          len_nxt   = len_clamped;
        end
      end
      LOAD: begin
        if (xfer) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == len - CW'(1)) state_nxt = LAST;
        end
      end
      LAST: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      row_en <= '0;
      row_d  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      len    <= len_nxt;
      row_en <= xfer ? (ROWS'(1) << cnt) : '0;
      if (xfer) row_d <= in_data;
      done   <= (state == LAST);
    end
  end

endmodule

// File: tb/tb_weight_load_seq.sv
// Bench for weight_load_seq: a fixed vector table, directed corner sequences,
// and random traffic compared cycle by cycle against a transaction-level model.
module tb_weight_load_seq;

  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int CW     = $clog2(ROWS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              test_mode;
  logic              start;
  logic [CW-1:0]     rows_to_load;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ROWS-1:0]   row_en;
  logic [DATA_W-1:0] row_d;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  weight_load_seq #(.DATA_W(DATA_W), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .test_mode(test_mode), .start(start),
    .rows_to_load(rows_to_load), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .row_en(row_en), .row_d(row_d), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int en_pulses = 0;

  // Reference model: a load is "active" from start until done; words_done counts
  // accepted words, and once it reaches target the next edge finishes the load.
  bit                m_active, m_finishing, m_done;
  int                m_words_done, m_target;
  logic [ROWS-1:0]   m_en;
  logic [DATA_W-1:0] m_d;

  typedef struct {
    logic st; logic [CW-1:0] rtl; logic v; logic [DATA_W-1:0] d; logic tm;
    logic ir; logic [ROWS-1:0] en; logic [DATA_W-1:0] rd; logic bsy; logic dn;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_finishing = 0; m_done = 0;
    m_words_done = 0; m_target = 0; m_en = '0; m_d = '0;
  endtask

  // Drive inputs just after a falling edge, then compare against the model.
  task automatic drive_check(input logic st, input logic [CW-1:0] rtl, input logic v,
                             input logic [DATA_W-1:0] d, input logic tm, input logic rs);
    start = st; rows_to_load = rtl; in_valid = v; in_data = d; test_mode = tm; reset = rs;
    #1;
    chk("in_ready", in_ready, m_active && !m_finishing && !tm);
    chk("row_en", row_en, m_en);
    chk("row_d", row_d, m_d);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    en_pulses += $countones(row_en);
  endtask

  // Take the rising edge and update the model from the held inputs.
  task automatic advance();
    bit rdy, xfer;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      rdy    = m_active && !m_finishing && !test_mode;
      xfer   = rdy && in_valid;
      m_en   = xfer ? ROWS'(1 << m_words_done) : '0;
      if (xfer) m_d = in_data;
      m_done = m_finishing;
      if (m_finishing) begin
        m_active = 0; m_finishing = 0;
      end else if (xfer) begin
        m_words_done++;
        if (m_words_done == m_target) m_finishing = 1;
      end else if (!m_active && start && !test_mode) begin
        m_active = 1; m_words_done = 0;
        m_target = (rows_to_load == 0 || int'(rows_to_load) > ROWS) ? ROWS : int'(rows_to_load);
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic st, input logic [CW-1:0] rtl, input logic v,
                      input logic [DATA_W-1:0] d, input logic tm, input logic rs);
    drive_check(st, rtl, v, d, tm, rs);
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 1);
  endtask

  initial begin
    //             st rtl  v  d      tm   ir en       rd     bsy dn
    tbl[0]  = '{1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 1'b1, 8'h11, 1'b0, 1'b1, 4'b0000, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 1'b1, 8'h22, 1'b0, 1'b1, 4'b0001, 8'h11, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 1'b1, 8'h33, 1'b0, 1'b1, 4'b0010, 8'h22, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 1'b1, 8'h44, 1'b0, 1'b1, 4'b0100, 8'h33, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 1'b1, 8'h55, 1'b0, 1'b0, 4'b1000, 8'h44, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'b0000, 8'h44, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 1'b1, 8'hA2, 1'b0, 1'b1, 4'b0001, 8'hA1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 1'b1, 8'hA3, 1'b0, 1'b0, 4'b0010, 8'hA2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'hA2, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 8'hA2, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 3'd0, 1'b1, 8'hB0, 1'b0, 1'b0, 4'b0000, 8'hA2, 1'b0, 1'b0};

    start = 0; rows_to_load = '0; in_valid = 0; in_data = '0; test_mode = 0; reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Fixed vectors: full load, partial load, test_mode blocking start.
    for (int k = 0; k < 15; k++) begin
      drive_check(tbl[k].st, tbl[k].rtl, tbl[k].v, tbl[k].d, tbl[k].tm, 1'b1);
      chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].ir);
      chk($sformatf("tbl%0d_row_en", k), row_en, tbl[k].en);
      chk($sformatf("tbl%0d_row_d", k), row_d, tbl[k].rd);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bsy);
      chk($sformatf("tbl%0d_done", k), done, tbl[k].dn);
      advance();
    end
    idle(1);

    // Clamped lengths, valid held past the last word.
    en_pulses = 0;
    step(1, 3'd0, 0, '0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 8'(i + 8'h60), 0, 1);
    idle(2);
    chk("clamp0_writes", en_pulses, 4);

    en_pulses = 0;
    step(1, 3'd7, 0, '0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 8'(i + 8'h70), 0, 1);
    idle(2);
    chk("clamp7_writes", en_pulses, 4);

    // Stall pattern on in_valid.
    begin
      logic [6:0] vpat;
      vpat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
      en_pulses = 0;
      step(1, 3'd4, 0, '0, 0, 1);
      for (int i = 0; i < 7; i++) step(0, '0, vpat[i], 8'(i + 8'h80), 0, 1);
      idle(3);
      chk("stall_writes", en_pulses, 4);
    end

    // test_mode pulse mid-load.
    begin
      logic [7:0] tpat;
      tpat = 8'b00001110;
      en_pulses = 0;
      step(1, 3'd4, 0, '0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 8'(i + 8'h90), tpat[i], 1);
      idle(2);
      chk("tmode_writes", en_pulses, 4);
    end

    // Reset after two transfers, then a fresh load from row 0.
    step(1, 3'd4, 0, '0, 0, 1);
    step(0, '0, 1, 8'hC0, 0, 1);
    step(0, '0, 1, 8'hC1, 0, 1);
    step(0, '0, 1, 8'hC2, 0, 0);
    idle(2);
    en_pulses = 0;
    step(1, 3'd3, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 8'(i + 8'hD0), 0, 1);
    idle(2);
    chk("after_reset_writes", en_pulses, 3);

    // start held high: ignored while busy, accepted in the done cycle.
    for (int i = 0; i < 12; i++) step(1, 3'd2, 1, 8'(i + 8'hE0), 0, 1);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, CW'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
           8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
